// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
//   Shared definitions for the multicycle RV32I sequencing controller:
//   - state_t       : controller state encoding
//   - OPC_*         : RV32I major opcodes (inst[6:0])
//   - CLS_*         : bit positions of the one-hot instruction class vector
//   - ALU_*, WB_*, NPC_* : encodings driven on alu_op_type,
//                     reg_writeback_select and next_pc_select
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // One-hot instruction class bit positions
  localparam int CLS_R       = 0;
  localparam int CLS_I       = 1;
  localparam int CLS_LOAD    = 2;
  localparam int CLS_STORE   = 3;
  localparam int CLS_BRANCH  = 4;
  localparam int CLS_JAL     = 5;
  localparam int CLS_JALR    = 6;
  localparam int CLS_LUI     = 7;
  localparam int CLS_AUIPC   = 8;
  localparam int CLS_NOP     = 9;
  localparam int CLS_ILLEGAL = 10;
  localparam int CLS_W       = 11;

  // alu_op_type
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP     = 2'd2;
  localparam logic [1:0] ALU_OP_IMM = 2'd3;

  // reg_writeback_select
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_IMM = 3'd2;
  localparam logic [2:0] WB_PC4 = 3'd3;

  // next_pc_select
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_PC_IMM = 2'd1;
  localparam logic [1:0] NPC_ALU    = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// -----------------------------------------------------------------------------
// opcode_classifier
//   Purely combinational map from the 7-bit major opcode to a one-hot class
//   vector (bit positions CLS_* in multicycle_pkg). Unknown opcodes set only
//   the ILLEGAL bit.
// Ports:
//   inst_opcode  in  7        opcode field of the instruction register
//   inst_class   out CLS_W    one-hot instruction class
// -----------------------------------------------------------------------------
module opcode_classifier
  import multicycle_pkg::*;
(
  input  logic [6:0]       inst_opcode,
  output logic [CLS_W-1:0] inst_class
);

  always_comb begin
    inst_class = '0;
    case (inst_opcode)
      OPC_OP:       inst_class[CLS_R]      = 1'b1;
      OPC_OP_IMM:   inst_class[CLS_I]      = 1'b1;
      OPC_LOAD:     inst_class[CLS_LOAD]   = 1'b1;
      OPC_STORE:    inst_class[CLS_STORE]  = 1'b1;
      OPC_BRANCH:   inst_class[CLS_BRANCH] = 1'b1;
      OPC_JAL:      inst_class[CLS_JAL]    = 1'b1;
      OPC_JALR:     inst_class[CLS_JALR]   = 1'b1;
      OPC_LUI:      inst_class[CLS_LUI]    = 1'b1;
      OPC_AUIPC:    inst_class[CLS_AUIPC]  = 1'b1;
      // FENCE and ECALL/EBREAK retire as no-ops on this core
      OPC_MISC_MEM: inst_class[CLS_NOP]    = 1'b1;
      OPC_SYSTEM:   inst_class[CLS_NOP]    = 1'b1;
      default:      inst_class[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Sequencing controller for the multicycle RV32I core. Walks each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WRITEBACK, stalling
//   on the level-based memory handshakes, and parks in HALT on an
//   unsupported opcode until reset.
// Ports:
//   clock                  in   core clock, rising edge
//   reset                  in   asynchronous, active-low
//   inst_opcode[6:0]       in   opcode from the instruction register
//   take_branch            in   branch condition, meaningful in EXECUTE
//   inst_mem_ready         in   instruction word returned
//   data_mem_ready         in   data access completed
//   inst_mem_req           out  instruction fetch request
//   inst_reg_write_enable  out  latch fetched word into IR
//   pc_write_enable        out  update PC (retire cycle)
//   regfile_write_enable   out  write rd
//   alu_operand_a_select   out  0 = rs1, 1 = PC
//   alu_operand_b_select   out  0 = rs2, 1 = imm
//   alu_op_type[1:0]       out  ADD / BRANCH / OP / OP_IMM
//   data_mem_read_enable   out  load request
//   data_mem_write_enable  out  store request
//   reg_writeback_select[2:0] out ALU / MEM / IMM / PC+4
//   next_pc_select[1:0]    out  PC+4 / PC+imm / ALU result
//   inst_retired           out  one pulse per retired instruction
//   illegal_inst           out  sticky halt indication
// -----------------------------------------------------------------------------
module multicycle_control_fsm
  import multicycle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       take_branch,
  input  logic       inst_mem_ready,
  input  logic       data_mem_ready,
  output logic       inst_mem_req,
  output logic       inst_reg_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [1:0] alu_op_type,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       inst_retired,
  output logic       illegal_inst
);

  state_t           state;
  state_t           state_next;
  logic [CLS_W-1:0] cls;

  opcode_classifier u_classifier (
    .inst_opcode (inst_opcode),
    .inst_class  (cls)
  );

  // State register: reset forces IDLE immediately, so every request drops
  // in the same cycle the reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (inst_mem_ready) state_next = DECODE;
      DECODE:  state_next = cls[CLS_ILLEGAL] ? HALT : EXECUTE;
      EXECUTE: begin
        if (cls[CLS_BRANCH] || cls[CLS_NOP]) begin
          state_next = FETCH;
        end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
          state_next = MEM;
        end else begin
          state_next = WRITEBACK;
        end
      end
      MEM: begin
        // Only a load needs a writeback cycle; a store retires here.
        if (data_mem_ready) state_next = cls[CLS_LOAD] ? WRITEBACK : FETCH;
      end
      WRITEBACK: state_next = FETCH;
      HALT:      state_next = HALT;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode from state and instruction class
  always_comb begin
    inst_mem_req          = 1'b0;
    inst_reg_write_enable = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_type           = ALU_ADD;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = WB_ALU;
    next_pc_select        = NPC_PC4;
    illegal_inst          = 1'b0;
    case (state)
      FETCH: begin
        inst_mem_req          = 1'b1;
        inst_reg_write_enable = inst_mem_ready;
      end
      EXECUTE: begin
        if (cls[CLS_R]) begin
          alu_op_type = ALU_OP;
        end
        if (cls[CLS_I]) begin
          alu_op_type          = ALU_OP_IMM;
          alu_operand_b_select = 1'b1;
        end
        if (cls[CLS_LOAD] || cls[CLS_STORE] || cls[CLS_JALR]) begin
          alu_op_type          = ALU_ADD;
          alu_operand_b_select = 1'b1;
        end
        if (cls[CLS_AUIPC]) begin
          alu_operand_a_select = 1'b1;
          alu_operand_b_select = 1'b1;
        end
        if (cls[CLS_BRANCH]) begin
          alu_op_type     = ALU_BRANCH;
          pc_write_enable = 1'b1;
          next_pc_select  = take_branch ? NPC_PC_IMM : NPC_PC4;
        end
        if (cls[CLS_NOP]) begin
          pc_write_enable = 1'b1;
        end
      end
      MEM: begin
        // Address controls stay put for the whole access.
        alu_op_type           = ALU_ADD;
        alu_operand_b_select  = 1'b1;
        data_mem_read_enable  = cls[CLS_LOAD];
        data_mem_write_enable = cls[CLS_STORE];
        pc_write_enable       = cls[CLS_STORE] && data_mem_ready;
      end
      WRITEBACK: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        if (cls[CLS_LOAD]) begin
          reg_writeback_select = WB_MEM;
        end else if (cls[CLS_LUI]) begin
          reg_writeback_select = WB_IMM;
        end else if (cls[CLS_JAL] || cls[CLS_JALR]) begin
          reg_writeback_select = WB_PC4;
        end
        if (cls[CLS_JAL]) begin
          next_pc_select = NPC_PC_IMM;
        end else if (cls[CLS_JALR]) begin
          next_pc_select = NPC_ALU;
        end
      end
      HALT: illegal_inst = 1'b1;
      default: ;
    endcase
  end

  assign inst_retired = pc_write_enable;

endmodule
